// File: rtl/matrix_mul_seq.sv
// Sequential NxN unsigned matrix multiplier, Y = A*B, built around one shared multiply-accumulate unit.
// Latency: a job accepted on edge T0 presents its result after edge T(N^3); back-to-back jobs cost N^3+2 cycles.
// Backpressure: in_ready is high only in IDLE; in DONE the result and ovf are held for as long as out_ready stays low.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   operand job handshake (in_ready == state is IDLE)
//   a_flat, b_flat        operands, element [i][j] at bits [(i*N+j)*DW +: DW]
//   out_valid / out_ready result handshake; y_flat is meaningful only while out_valid is high
//   y_flat                result, element [i][j] at bits [(i*N+j)*OW +: OW]
//   ovf                   sticky per job: an element was clamped (MATMUL_SAT_EN builds only, otherwise 0)
//
// Build option: define MATMUL_SAT_EN to clamp elements that exceed 2^OW-1 instead of keeping the low OW bits.
module matrix_mul_seq #(
   parameter int N  = 4,
   parameter int DW = 4,
   parameter int OW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*N*DW-1:0] a_flat,
   input  logic [N*N*DW-1:0] b_flat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*OW-1:0] y_flat,
   output logic              ovf
);

   localparam int IW = $clog2(N);
   localparam int PW = 2 * DW;
   // One spare bit above the worst-case sum of N full-scale products, so acc never wraps.
   localparam int AW = 2 * DW + $clog2(N) + 1;

`ifdef MATMUL_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N*N*DW-1:0] a_reg;
   logic [N*N*DW-1:0] b_reg;
   logic [N*N*OW-1:0] y_reg;
   logic [AW-1:0]     acc;
   logic [AW-1:0]     sum;
   logic [IW-1:0]     i;
   logic [IW-1:0]     j;
   logic [IW-1:0]     k;
   logic [DW-1:0]     a_el;
   logic [DW-1:0]     b_el;
   logic [PW-1:0]     prod;
   logic [OW-1:0]     elem;
   logic              elem_sat;
   logic              ovf_q;
   logic              i_last;
   logic              j_last;
   logic              k_last;
   logic              accept;
   logic              last_mac;

   // ---------------- multiply-accumulate datapath ----------------
   assign a_el = a_reg[(int'(i) * N + int'(k)) * DW +: DW];
   assign b_el = b_reg[(int'(k) * N + int'(j)) * DW +: DW];
   assign prod = PW'(a_el) * PW'(b_el);
   assign sum  = acc + AW'(prod);

   // Element narrowing: only possible when the result bus is narrower than the accumulator.
   generate
      if (OW < AW) begin : g_clip
         logic hi;
         assign hi       = |sum[AW-1:OW];
         assign elem_sat = hi & SAT_EN;
         assign elem     = elem_sat ? {OW{1'b1}} : sum[OW-1:0];
      end else begin : g_full
         assign elem_sat = 1'b0;
         assign elem     = OW'(sum);
      end
   endgenerate

   assign i_last   = (i == IW'(N - 1));
   assign j_last   = (j == IW'(N - 1));
   assign k_last   = (k == IW'(N - 1));
   assign last_mac = i_last & j_last & k_last;
   assign accept   = in_valid & (state == IDLE);

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            if (last_mac) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- operand capture, indices, accumulator, result ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         y_reg <= '0;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         a_reg <= a_flat;
         b_reg <= b_flat;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
         k     <= '0;
         ovf_q <= 1'b0;
      end else if (state == COMPUTE) begin
         if (k_last) begin
            // Final product of the dot product goes straight into the element; acc restarts.
            y_reg[(int'(i) * N + int'(j)) * OW +: OW] <= elem;
            ovf_q <= ovf_q | elem_sat;
            acc   <= '0;
            k     <= '0;
            if (j_last) begin
               j <= '0;
               i <= i_last ? '0 : i + 1'b1;
            end else begin
               j <= j + 1'b1;
            end
         end else begin
            acc <= sum;
            k   <= k + 1'b1;
         end
      end
   end

   assign y_flat = y_reg;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Scoreboard bench for matrix_mul_seq: three instances (4x4x4->16, 4x4x4->9, 3x3x8->18).
// Stimulus pushes expected results into per-instance queues; negedge monitors pop and compare.
module tb_matrix_mul_seq;

   localparam int N0 = 4, DW0 = 4, OW0 = 16;
   localparam int N1 = 4, DW1 = 4, OW1 = 9;
   localparam int N2 = 3, DW2 = 8, OW2 = 18;

`ifdef MATMUL_SAT_EN
   localparam int EXP1     = 511;
   localparam bit EXP1_OVF = 1'b1;
`else
   localparam int EXP1     = 388;
   localparam bit EXP1_OVF = 1'b0;
`endif

   typedef struct {
      logic [255:0] y;
      logic         ovf;
      int           acc_cyc;
   } job_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   logic                    in_valid0, in_ready0, out_valid0, out_ready0, ovf0;
   logic [N0*N0*DW0-1:0]    a_flat0, b_flat0;
   logic [N0*N0*OW0-1:0]    y_flat0;
   logic                    in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
   logic [N1*N1*DW1-1:0]    a_flat1, b_flat1;
   logic [N1*N1*OW1-1:0]    y_flat1;
   logic                    in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
   logic [N2*N2*DW2-1:0]    a_flat2, b_flat2;
   logic [N2*N2*OW2-1:0]    y_flat2;

   job_t q0[$];
   job_t q1[$];
   job_t q2[$];
   job_t e0, e1, e2, jb;
   logic seen0, chk_rdy0;
   logic [N0*N0*OW0-1:0] held0;

   matrix_mul_seq #(.N(N0), .DW(DW0), .OW(OW0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
      .a_flat(a_flat0), .b_flat(b_flat0), .out_valid(out_valid0), .out_ready(out_ready0),
      .y_flat(y_flat0), .ovf(ovf0));

   matrix_mul_seq #(.N(N1), .DW(DW1), .OW(OW1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a_flat(a_flat1), .b_flat(b_flat1), .out_valid(out_valid1), .out_ready(out_ready1),
      .y_flat(y_flat1), .ovf(ovf1));

   matrix_mul_seq #(.N(N2), .DW(DW2), .OW(OW2)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a_flat(a_flat2), .b_flat(b_flat2), .out_valid(out_valid2), .out_ready(out_ready2),
      .y_flat(y_flat2), .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference product for the 4x4 instance, straight triple loop.
   function automatic logic [N0*N0*OW0-1:0] mm(input logic [N0*N0*DW0-1:0] a,
                                               input logic [N0*N0*DW0-1:0] b);
      logic [N0*N0*OW0-1:0] y;
      int s;
      y = '0;
      for (int r = 0; r < N0; r++) begin
         for (int c = 0; c < N0; c++) begin
            s = 0;
            for (int m = 0; m < N0; m++) begin
               s += int'(a[(r*N0+m)*DW0 +: DW0]) * int'(b[(m*N0+c)*DW0 +: DW0]);
            end
            y[(r*N0+c)*OW0 +: OW0] = OW0'(s);
         end
      end
      return y;
   endfunction

   // Offer a job to u0, wait (bounded) for acceptance, then queue its expected result.
   task automatic issue0(input logic [N0*N0*DW0-1:0] a, input logic [N0*N0*DW0-1:0] b,
                         input logic [N0*N0*OW0-1:0] y, input logic ov);
      int t;
      a_flat0   = a;
      b_flat0   = b;
      in_valid0 = 1'b1;
      t = 0;
      while (!in_ready0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("accept_wait", in_ready0, 1);
      @(posedge clk); #1;
      in_valid0  = 1'b0;
      jb.y       = 256'(y);
      jb.ovf     = ov;
      jb.acc_cyc = cyc;
      q0.push_back(jb);
   endtask

   task automatic drain0();
      int t;
      t = 0;
      while (q0.size() != 0 && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_u0", q0.size(), 0);
   endtask

   // Monitor for u0: latency, hold-under-backpressure, in_ready behaviour, result compare.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen0    = 1'b0;
         chk_rdy0 = 1'b0;
      end else begin
         if (chk_rdy0) begin
            chk("u0_ready_after_hs", in_ready0, 1);
            chk_rdy0 = 1'b0;
         end
         if (out_valid0) begin
            if (q0.size() == 0) begin
               chk("u0_unexpected_out", out_valid0, 0);
            end else begin
               if (!seen0) begin
                  chk("u0_latency", cyc - q0[0].acc_cyc, N0*N0*N0);
                  held0 = y_flat0;
                  seen0 = 1'b1;
               end else begin
                  chk("u0_hold", y_flat0, held0);
               end
               chk("u0_busy_in_done", in_ready0, 0);
               if (out_ready0) begin
                  e0 = q0.pop_front();
                  chk("u0_y", y_flat0, e0.y);
                  chk("u0_ovf", ovf0, e0.ovf);
                  seen0    = 1'b0;
                  chk_rdy0 = 1'b1;
               end
            end
         end
      end
   end

   // Monitors for u1/u2: out_ready is held high, so the first valid cycle is the handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid1) begin
         if (q1.size() == 0) begin
            chk("u1_unexpected_out", out_valid1, 0);
         end else begin
            e1 = q1.pop_front();
            chk("u1_latency", cyc - e1.acc_cyc, N1*N1*N1);
            chk("u1_y", y_flat1, e1.y);
            chk("u1_ovf", ovf1, e1.ovf);
         end
      end
      if (rst_n && out_valid2) begin
         if (q2.size() == 0) begin
            chk("u2_unexpected_out", out_valid2, 0);
         end else begin
            e2 = q2.pop_front();
            chk("u2_latency", cyc - e2.acc_cyc, N2*N2*N2);
            chk("u2_y", y_flat2, e2.y);
            chk("u2_ovf", ovf2, e2.ovf);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N0*N0*DW0-1:0] ident, seq, rseq, ones, xa, xb;
      logic [N0*N0*OW0-1:0] ymax;
      logic [N1*N1*OW1-1:0] y1e;
      logic [N2*N2*OW2-1:0] y2e;
      int t;

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
      out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
      a_flat0 = '0; b_flat0 = '0; a_flat1 = '0; b_flat1 = '0; a_flat2 = '0; b_flat2 = '0;

      ident = 64'h1000_0100_0010_0001;
      seq   = 64'hFEDC_BA98_7654_3210;
      rseq  = 64'h0123_4567_89AB_CDEF;
      ones  = 64'h1111_1111_1111_1111;
      for (int e = 0; e < N0*N0; e++) ymax[e*OW0 +: OW0] = 16'd900;
      for (int e = 0; e < N1*N1; e++) y1e[e*OW1 +: OW1] = OW1'(EXP1);
      for (int e = 0; e < N2*N2; e++) y2e[e*OW2 +: OW2] = 18'd195075;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready0, 1);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_y", y_flat0, 0);
      chk("rst_y_u2", y_flat2, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Narrow-output and N=3 instances run alongside the u0 sequence.
      chk("u1_idle_ready", in_ready1, 1);
      chk("u2_idle_ready", in_ready2, 1);
      a_flat1 = '1; b_flat1 = '1; a_flat2 = '1; b_flat2 = '1;
      in_valid1 = 1'b1; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0; in_valid2 = 1'b0;
      jb.y = 256'(y1e); jb.ovf = EXP1_OVF; jb.acc_cyc = cyc; q1.push_back(jb);
      jb.y = 256'(y2e); jb.ovf = 1'b0;     jb.acc_cyc = cyc; q2.push_back(jb);

      // Identity then all-max, back to back.
      issue0(ident, seq, mm(ident, seq), 1'b0);
      issue0('1, '1, ymax, 1'b0);
      drain0();

      // Backpressure: hold the first result 10 cycles, then chain a second job.
      out_ready0 = 1'b0;
      issue0(seq, rseq, mm(seq, rseq), 1'b0);
      t = 0;
      while (!out_valid0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_wait", out_valid0, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("held_valid", out_valid0, 1);
      out_ready0 = 1'b1;
      xa = 64'h3141_5926_5358_9793;
      xb = 64'h2718_2818_2845_9045;
      issue0(xa, xb, mm(xa, xb), 1'b0);
      // Offers during COMPUTE must be ignored.
      a_flat0 = ~xa; b_flat0 = ~xb; in_valid0 = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      drain0();

      // Reset mid-job, then a fresh job.
      issue0(seq, seq, mm(seq, seq), 1'b0);
      repeat (30) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      q0.delete();
      chk("midrst_out_valid", out_valid0, 0);
      chk("midrst_in_ready", in_ready0, 1);
      chk("midrst_y", y_flat0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      issue0(ones, seq, mm(ones, seq), 1'b0);
      drain0();

      t = 0;
      while ((q1.size() != 0 || q2.size() != 0) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_u1", q1.size(), 0);
      chk("drain_u2", q2.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
